// File: rtl/csa_accumulator.sv
// ----------------------------------------------------------------------------
// csa_accumulator
//
// Sequential carry-save accumulator for the radix-16 Booth multiplier
// datapath. One pre-shifted, sign-extended partial product is taken per
// accepted cycle. The running total is kept in redundant sum/carry form
// using a single row of full-adder cells, so the cycle time never depends
// on a carry chain. After N_PP terms the sum/carry pair is presented to the
// final stage over a valid/ready handshake.
//
// Optional feature macro: CSA_FINAL_CPA_EN
//   defined   : adds a FINAL state and an ACC_W-bit carry-propagate adder;
//               out_result carries the resolved sum (one extra cycle latency).
//   undefined : no FINAL state, no adder; out_result is tied to zero and the
//               consumer resolves out_sum + out_carry itself.
//
// Parameters:
//   ACC_W  accumulator width (>= 2); all arithmetic is modulo 2^ACC_W
//   N_PP   partial products per operation (>= 1)
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst_n      synchronous active-low reset
//   in_valid   pp_in holds a valid partial product
//   in_ready   block can accept a term this cycle (registered)
//   pp_in      two's-complement partial product, pre-shifted/sign-extended
//   out_valid  out_sum/out_carry/out_result are valid (registered)
//   out_ready  downstream consumes the output
//   out_sum    redundant sum vector
//   out_carry  redundant carry vector, already aligned (weight 1 per bit)
//   out_result resolved result (zero unless CSA_FINAL_CPA_EN is defined)
// ----------------------------------------------------------------------------
module csa_accumulator #(
  parameter int ACC_W = 16,
  parameter int N_PP  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ACC_W-1:0] pp_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [ACC_W-1:0] out_carry,
  output logic [ACC_W-1:0] out_result
);

  // Counter must hold the value N_PP itself.
  localparam int CNT_W = $clog2(N_PP + 1);

  // Counter value held while the final term of a batch is being accepted.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_PP - 1);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
  localparam bit               SINGLE   = (N_PP == 1);

`ifdef CSA_FINAL_CPA_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_FINAL = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // After the last term the pair still has to be resolved.
  localparam state_t ST_END    = ST_FINAL;
  localparam logic   END_VALID = 1'b0;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd3
  } state_t;

  // After the last term the pair goes straight to the output.
  localparam state_t ST_END    = ST_DONE;
  localparam logic   END_VALID = 1'b1;
`endif

  // --------------------------------------------------------------------------
  // Full-adder row helpers. Each bit position is an independent full adder;
  // the majority output has weight 2, so it is shifted up one position and
  // the carry out of the MSB falls off (modulo 2^ACC_W).
  // --------------------------------------------------------------------------
  function automatic logic [ACC_W-1:0] csa_sum(
    input logic [ACC_W-1:0] a,
    input logic [ACC_W-1:0] b,
    input logic [ACC_W-1:0] c
  );
    return a ^ b ^ c;
  endfunction

  function automatic logic [ACC_W-1:0] csa_carry(
    input logic [ACC_W-1:0] a,
    input logic [ACC_W-1:0] b,
    input logic [ACC_W-1:0] c
  );
    logic [ACC_W-1:0] maj;
    maj = (a & b) | (a & c) | (b & c);
    return {maj[ACC_W-2:0], 1'b0};
  endfunction

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [ACC_W-1:0] sum_r;
  logic [ACC_W-1:0] carry_r;
  logic             in_ready_r;
  logic             out_valid_r;

  logic             accept_s;
  logic             last_term_s;
  logic [ACC_W-1:0] csa_sum_s;
  logic [ACC_W-1:0] csa_carry_s;

  // Acceptance uses the registered ready, so pp_in is ignored whenever
  // in_ready is low regardless of in_valid.
  assign accept_s    = in_valid & in_ready_r;
  assign last_term_s = (cnt_r == LAST_CNT);
  assign csa_sum_s   = csa_sum(sum_r, carry_r, pp_in);
  assign csa_carry_s = csa_carry(sum_r, carry_r, pp_in);

`ifdef CSA_FINAL_CPA_EN
  logic [ACC_W-1:0] result_r;
  logic [ACC_W-1:0] cpa_s;

  // Carry-propagate resolution of the redundant pair; carry-out discarded.
  assign cpa_s = sum_r + carry_r;

  // Resolved result register, loaded only in FINAL.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_r <= {ACC_W{1'b0}};
    end else if (state_r == ST_FINAL) begin
      result_r <= cpa_s;
    end else begin
      result_r <= result_r;
    end
  end

  assign out_result = result_r;
`else
  assign out_result = {ACC_W{1'b0}};
`endif

  // Control FSM with the accumulator pair and the registered handshake flags.
  // in_ready/out_valid are loaded with the value matching the next state so
  // they are true flop outputs with no decode after the register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      sum_r       <= {ACC_W{1'b0}};
      carry_r     <= {ACC_W{1'b0}};
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          // First term of a batch loads the pair directly.
          in_ready_r <= 1'b1;
          if (accept_s) begin
            sum_r   <= pp_in;
            carry_r <= {ACC_W{1'b0}};
            cnt_r   <= ONE_CNT;
            if (SINGLE) begin
              state_r     <= ST_END;
              in_ready_r  <= 1'b0;
              out_valid_r <= END_VALID;
            end else begin
              state_r <= ST_ACCUM;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_ACCUM: begin
          in_ready_r <= 1'b1;
          if (accept_s) begin
            sum_r   <= csa_sum_s;
            carry_r <= csa_carry_s;
            cnt_r   <= cnt_r + ONE_CNT;
            if (last_term_s) begin
              state_r     <= ST_END;
              in_ready_r  <= 1'b0;
              out_valid_r <= END_VALID;
            end else begin
              state_r <= ST_ACCUM;
            end
          end else begin
            state_r <= ST_ACCUM;
          end
        end

`ifdef CSA_FINAL_CPA_EN
        ST_FINAL: begin
          // result_r is loaded by its own register this cycle.
          state_r     <= ST_DONE;
          in_ready_r  <= 1'b0;
          out_valid_r <= 1'b1;
        end
`endif

        ST_DONE: begin
          // in_ready stays low through the handshake cycle, which forces one
          // idle cycle before the next batch can start.
          in_ready_r <= out_ready;
          if (out_ready) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            out_valid_r <= 1'b0;
          end else begin
            state_r     <= ST_DONE;
            out_valid_r <= 1'b1;
          end
        end

        default: begin
          // Unreachable encoding: drop any partial work and restart cleanly.
          state_r     <= ST_IDLE;
          cnt_r       <= {CNT_W{1'b0}};
          sum_r       <= {ACC_W{1'b0}};
          carry_r     <= {ACC_W{1'b0}};
          in_ready_r  <= 1'b0;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_sum   = sum_r;
  assign out_carry = carry_r;

endmodule

// File: doc/csa_accumulator.md
Name: csa_accumulator

Overview:
- Sequential carry-save accumulator for the radix-16 Booth multiplier datapath.
- Accepts one pre-shifted, sign-extended partial product per cycle over a valid/ready handshake.
- Keeps the running total in redundant sum/carry form using one row of full-adder cells.
- After N_PP terms, presents the sum/carry pair, optionally resolved to a single result, to the final stage.

Parameters:
- ACC_W, 16, accumulator width in bits; all arithmetic is modulo 2^ACC_W.
- N_PP, 4, partial products per operation; must be at least 1.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  pp_in holds a valid partial product.
- in_ready  output  1  block can accept a term this cycle.
- pp_in  input  ACC_W  two's-complement partial product, already shifted and sign-extended by the caller.
- out_valid  output  1  out_sum, out_carry and out_result are valid.
- out_ready  input  1  downstream consumes the output.
- out_sum  output  ACC_W  redundant sum vector.
- out_carry  output  ACC_W  redundant carry vector, already aligned (weight 1 per bit).
- out_result  output  ACC_W  resolved result; see Optional Feature.

Behaviour:
- Reset is synchronous and active-low, sampled on the rising edge of clk. While rst_n = 0:
  - state = IDLE, term counter = 0, sum_q = 0, carry_q = 0, result_q = 0;
  - in_ready = 0, out_valid = 0, out_sum/out_carry/out_result = 0.
- Reset asserted mid-operation (any state) discards all partial work; no output is produced for that batch.
- A term is accepted in a cycle where in_valid = 1 and in_ready = 1.
- States:
  - IDLE: in_ready = 1. On accept: sum_q <= pp_in, carry_q <= 0, cnt <= 1. Go to DONE if N_PP = 1, else ACCUM.
  - ACCUM: in_ready = 1. On accept: bitwise full-add of (sum_q, carry_q, pp_in); sum_q <= XOR; carry_q <= majority shifted left by 1, LSB = 0, MSB carry dropped; cnt <= cnt + 1. When the accepted term is number N_PP, go to DONE, or to FINAL when CSA_FINAL_CPA_EN is defined. With no accept, hold all state.
  - FINAL (feature only): in_ready = 0. result_q <= sum_q + carry_q mod 2^ACC_W; go to DONE.
  - DONE: in_ready = 0, out_valid = 1. Outputs are stable while out_ready = 0. When out_ready = 1: cnt <= 0, go to IDLE.
- Invariant: after every accept, (sum_q + carry_q) mod 2^ACC_W equals the sum of accepted terms mod 2^ACC_W.
- Outputs are registered; out_sum = sum_q and out_carry = carry_q whenever out_valid = 1.
- Latency: last term accepted at edge t gives out_valid = 1 from cycle t+1. With the feature, out_valid = 1 from cycle t+2.
- There is always one idle cycle between output handshake and next acceptance: in_ready is 0 in the cycle where out_valid & out_ready = 1.
- in_valid gaps are allowed anywhere; the counter advances only on accept.
- pp_in is ignored while in_ready = 0.
- Counter width is clog2(N_PP+1); it never exceeds N_PP.

Optional Feature:
- Macro: CSA_FINAL_CPA_EN.
- Defined:
  - adds the FINAL state and a carry-propagate adder (ACC_W-bit, carry-out discarded);
  - out_result = result_q, valid with out_valid; end-to-end latency +1 cycle.
- Undefined:
  - no FINAL state and no adder;
  - out_result is tied to 0;
  - the consumer resolves out_sum + out_carry itself.

Test Plan:
1. ACC_W=16, N_PP=4, terms 0x0003, 0x0005, 0xFFFF, 0x0010 on consecutive cycles -> out_valid at t+1 (t+2 with feature); (out_sum + out_carry) mod 2^16 = 0x0017; out_result = 0x0017 with feature, else 0.
2. Wrap-around: four terms of 0x8000 -> sum+carry = 0x0000; then 0x7FFF, 0x0001, 0x0000, 0x0000 -> 0x8000; no X on carry MSB.
3. Backpressure and gaps: in_valid toggled 1,0,0,1,1,0,1 supplying 0x0001..0x0004 -> output only after the 4th accept; hold out_ready = 0 for 5 cycles -> outputs stable, in_ready = 0; out_ready pulse -> IDLE next cycle, in_ready = 1 one cycle later.
4. Reset mid-operation: accept 2 of 4 terms, drive rst_n = 0 for 1 cycle -> all outputs 0 next cycle. New batch 0x0002 x4 -> result 0x0008, uncontaminated by the earlier terms.
5. N_PP=1: single term 0xABCD -> out_sum = 0xABCD, out_carry = 0x0000 at t+1.
6. Randomised cross-check vs reference model: 1000 batches, ACC_W=24, N_PP=8, random valid/ready -> invariant holds after every accept, result matches the modular sum.
